cacheline_burst_adaptor: RTL and testbench



---
 rtl/cacheline_burst_adaptor.sv | 186 ++++++++++++++++++
 tb/tb_cacheline_burst_adaptor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_burst_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_burst_adaptor
//
// Memory-side responder for the cache's physical-memory port. It takes one
// line request at a time and turns it into a BEATS-beat burst on the
// main-memory side:
//   - read  : collects BEATS returned beats (beat 0 = least-significant bits)
//             into a line, then presents it on pmem_rdata.
//   - write : serialises the latched line onto burst_wdata, one beat per
//             accepted burst_resp.
// When the whole burst has finished, pmem_resp pulses for exactly one cycle.
// Every output comes straight from a flop; no input reaches an output
// combinationally.
//
// Ports
//   clk            system clock, all state on the rising edge
//   rst            asynchronous active-low reset
//   pmem_address   line address from the cache
//   pmem_read      line read request, held until pmem_resp
//   pmem_write     line write request, held until pmem_resp
//   pmem_wdata     line to write
//   pmem_rdata     assembled read line; holds until the next read completes
//   pmem_resp      one-cycle completion strobe
//   burst_address  line-aligned burst address
//   burst_read     burst read request
//   burst_write    burst write request
//   burst_wdata    current write beat
//   burst_rdata    returned read beat
//   burst_resp     beat accepted (write) / beat valid (read) strobe
// -----------------------------------------------------------------------------
module cacheline_burst_adaptor #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pmem_address,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic [31:0]       burst_address,
    output logic              burst_read,
    output logic              burst_write,
    output logic [BEAT_W-1:0] burst_wdata,
    input  logic [BEAT_W-1:0] burst_rdata,
    input  logic              burst_resp
);

    // Derived beat count; kept local so it always tracks LINE_W/BEAT_W.
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    // Clears the byte-offset-within-line bits of the address.
    localparam logic [31:0] ALIGN_MASK = ~(32'(LINE_W / 8) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Shared line buffer: holds the write line during WR and gathers beats
    // during RD. pmem_rdata is a separate register so writes never disturb it.
    logic [LINE_W-1:0] line_q, line_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic [31:0]       addr_q, addr_d;
    logic [BEAT_W-1:0] wdata_q, wdata_d;
    logic              resp_q, resp_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;

    // Next-state and next-output logic. The output flops are loaded with the
    // value they must show in the state being entered, which keeps every
    // output registered while still meeting the 1-4 / 5 cycle timing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = '0;
        resp_d  = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // burst_resp is deliberately ignored here.
                if (pmem_write) begin
                    // Write wins over a simultaneous read so that a dirty
                    // writeback lands before the fill that replaces it.
                    state_d = WR;
                    cnt_d   = '0;
                    addr_d  = pmem_address & ALIGN_MASK;
                    line_d  = pmem_wdata;
                    wdata_d = pmem_wdata[BEAT_W-1:0];
                    wr_d    = 1'b1;
                end else if (pmem_read) begin
                    state_d = RD;
                    cnt_d   = '0;
                    addr_d  = pmem_address & ALIGN_MASK;
                    rd_d    = 1'b1;
                end
            end

            RD: begin
                rd_d = 1'b1;
                if (burst_resp) begin
                    line_d[BEAT_W*int'(cnt_q) +: BEAT_W] = burst_rdata;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        rd_d    = 1'b0;
                        rdata_d = line_d;
                        resp_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            WR: begin
                wr_d    = 1'b1;
                wdata_d = wdata_q;
                if (burst_resp) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        wr_d    = 1'b0;
                        wdata_d = '0;
                        resp_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        wdata_d = line_q[BEAT_W*int'(cnt_d) +: BEAT_W];
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. An aborted burst is simply dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            resp_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign pmem_rdata    = rdata_q;
    assign pmem_resp     = resp_q;
    assign burst_address = addr_q;
    assign burst_read    = rd_q;
    assign burst_write   = wr_q;
    assign burst_wdata   = wdata_q;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// -----------------------------------------------------------------------------
// tb_cacheline_burst_adaptor
//
// Directed bench for cacheline_burst_adaptor. A table of per-cycle vectors
// covers contiguous read, stalled write and simultaneous read/write; hand
// sequences cover reset mid-burst and a stray burst_resp while idle.
// Inputs are driven 1 time unit after the rising edge and outputs are checked
// at the same point after the following edge.
// -----------------------------------------------------------------------------
module tb_cacheline_burst_adaptor;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;

    logic              clk;
    logic              rst;
    logic [31:0]       pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic [31:0]       burst_address;
    logic              burst_read;
    logic              burst_write;
    logic [BEAT_W-1:0] burst_wdata;
    logic [BEAT_W-1:0] burst_rdata;
    logic              burst_resp;

    cacheline_burst_adaptor #(
        .LINE_W(LINE_W),
        .BEAT_W(BEAT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .burst_address(burst_address),
        .burst_read   (burst_read),
        .burst_write  (burst_write),
        .burst_wdata  (burst_wdata),
        .burst_rdata  (burst_rdata),
        .burst_resp   (burst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic              rd;
        logic              wr;
        logic [31:0]       addr;
        logic              bresp;
        logic [BEAT_W-1:0] brdata;
        logic              e_rd;
        logic              e_wr;
        logic              e_resp;
        logic [BEAT_W-1:0] e_wdata;
        logic [31:0]       e_addr;
        logic [LINE_W-1:0] e_line;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] WA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] WB = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0] WC = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] WD = 64'hDDDD_DDDD_DDDD_DDDD;
    localparam logic [255:0] RLINE = {B4, B3, B2, B1};
    localparam logic [255:0] WLINE = {WD, WC, WB, WA};

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic bresp, input logic [63:0] brdata,
                                input logic e_rd, input logic e_wr, input logic e_resp,
                                input logic [63:0] e_wdata, input logic [31:0] e_addr,
                                input logic [255:0] e_line);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.bresp = bresp; v.brdata = brdata;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_resp = e_resp; v.e_wdata = e_wdata;
        v.e_addr = e_addr; v.e_line = e_line;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic bresp, input logic [63:0] brdata);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        burst_resp   = bresp;
        burst_rdata  = brdata;
    endtask

    task automatic chk_idle_outputs(input string tag, input logic [255:0] e_line,
                                    input logic [31:0] e_addr);
        chk({tag, ".ctl"}, {253'd0, burst_read, burst_write, pmem_resp}, 256'd0);
        chk({tag, ".wdata"}, {192'd0, burst_wdata}, 256'd0);
        chk({tag, ".addr"}, {224'd0, burst_address}, {224'd0, e_addr});
        chk({tag, ".rdata"}, pmem_rdata, e_line);
    endtask

    initial begin
        // ---------------- vector table ----------------
        // Contiguous read at 0x1234 -> burst address 0x1220.
        vecs.push_back(mk(1, 0, 32'h1234, 0, 64'h0, 1, 0, 0, 64'h0, 32'h1220, 256'h0));
        vecs.push_back(mk(1, 0, 32'h1234, 1, B1,    1, 0, 0, 64'h0, 32'h1220, 256'h0));
        vecs.push_back(mk(1, 0, 32'h1234, 1, B2,    1, 0, 0, 64'h0, 32'h1220, 256'h0));
        vecs.push_back(mk(1, 0, 32'h1234, 1, B3,    1, 0, 0, 64'h0, 32'h1220, 256'h0));
        vecs.push_back(mk(1, 0, 32'h1234, 1, B4,    0, 0, 1, 64'h0, 32'h1220, RLINE));
        vecs.push_back(mk(1, 0, 32'h1234, 0, 64'h0, 0, 0, 0, 64'h0, 32'h1220, RLINE));
        vecs.push_back(mk(0, 0, 32'h1234, 0, 64'h0, 0, 0, 0, 64'h0, 32'h1220, RLINE));
        // Write at 0xABFF, burst_resp every other cycle; read line must persist.
        vecs.push_back(mk(0, 1, 32'hABFF, 0, 64'h0, 0, 1, 0, WA,    32'hABE0, RLINE));
        vecs.push_back(mk(0, 1, 32'hABFF, 1, 64'h0, 0, 1, 0, WB,    32'hABE0, RLINE));
        vecs.push_back(mk(0, 1, 32'hABFF, 0, 64'h0, 0, 1, 0, WB,    32'hABE0, RLINE));
        vecs.push_back(mk(0, 1, 32'hABFF, 1, 64'h0, 0, 1, 0, WC,    32'hABE0, RLINE));
        vecs.push_back(mk(0, 1, 32'hABFF, 0, 64'h0, 0, 1, 0, WC,    32'hABE0, RLINE));
        vecs.push_back(mk(0, 1, 32'hABFF, 1, 64'h0, 0, 1, 0, WD,    32'hABE0, RLINE));
        vecs.push_back(mk(0, 1, 32'hABFF, 0, 64'h0, 0, 1, 0, WD,    32'hABE0, RLINE));
        vecs.push_back(mk(0, 1, 32'hABFF, 1, 64'h0, 0, 0, 1, 64'h0, 32'hABE0, RLINE));
        vecs.push_back(mk(0, 1, 32'hABFF, 0, 64'h0, 0, 0, 0, 64'h0, 32'hABE0, RLINE));
        vecs.push_back(mk(0, 0, 32'hABFF, 0, 64'h0, 0, 0, 0, 64'h0, 32'hABE0, RLINE));
        // Simultaneous read+write at 0x5555: write burst first, no read burst.
        vecs.push_back(mk(1, 1, 32'h5555, 0, 64'h0, 0, 1, 0, WA,    32'h5540, RLINE));
        vecs.push_back(mk(1, 1, 32'h5555, 1, 64'h0, 0, 1, 0, WB,    32'h5540, RLINE));
        vecs.push_back(mk(1, 1, 32'h5555, 1, 64'h0, 0, 1, 0, WC,    32'h5540, RLINE));
        vecs.push_back(mk(1, 1, 32'h5555, 1, 64'h0, 0, 1, 0, WD,    32'h5540, RLINE));
        vecs.push_back(mk(1, 1, 32'h5555, 1, 64'h0, 0, 0, 1, 64'h0, 32'h5540, RLINE));
        vecs.push_back(mk(1, 1, 32'h5555, 0, 64'h0, 0, 0, 0, 64'h0, 32'h5540, RLINE));
        vecs.push_back(mk(0, 0, 32'h5555, 0, 64'h0, 0, 0, 0, 64'h0, 32'h5540, RLINE));

        // ---------------- reset then idle ----------------
        rst        = 1'b0;
        pmem_wdata = WLINE;
        drive(0, 0, 32'h0, 0, 64'h0);
        step();
        chk_idle_outputs("reset", 256'h0, 32'h0);
        step();
        rst = 1'b1;
        step();
        step();
        chk_idle_outputs("idle", 256'h0, 32'h0);

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].bresp, vecs[i].brdata);
            step();
            chk($sformatf("vec%0d.ctl", i),
                {253'd0, burst_read, burst_write, pmem_resp},
                {253'd0, vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_resp});
            chk($sformatf("vec%0d.wdata", i), {192'd0, burst_wdata}, {192'd0, vecs[i].e_wdata});
            chk($sformatf("vec%0d.addr", i), {224'd0, burst_address}, {224'd0, vecs[i].e_addr});
            chk($sformatf("vec%0d.rdata", i), pmem_rdata, vecs[i].e_line);
        end

        // ---------------- reset mid-read ----------------
        drive(1, 0, 32'h8000, 0, 64'h0);
        step();
        chk("midrst.start", {224'd0, burst_address}, {224'd0, 32'h8000});
        drive(1, 0, 32'h8000, 1, 64'h0101_0101_0101_0101);
        step();
        drive(1, 0, 32'h8000, 1, 64'h0202_0202_0202_0202);
        step();
        drive(1, 0, 32'h8000, 1, 64'h0303_0303_0303_0303);
        step();
        chk("midrst.busy", {255'd0, burst_read}, 256'd1);
        drive(0, 0, 32'h8000, 0, 64'h0);
        #3;
        rst = 1'b0;
        #1;
        chk_idle_outputs("midrst.async", 256'h0, 32'h0);
        step();
        rst = 1'b1;
        drive(1, 0, 32'h0040, 0, 64'h0);
        step();
        chk("midrst.new.ctl", {253'd0, burst_read, burst_write, pmem_resp}, 256'd4);
        chk("midrst.new.addr", {224'd0, burst_address}, {224'd0, 32'h0040});
        drive(1, 0, 32'h0040, 1, 64'hF1F1_F1F1_F1F1_F1F1);
        step();
        drive(1, 0, 32'h0040, 1, 64'hF2F2_F2F2_F2F2_F2F2);
        step();
        drive(1, 0, 32'h0040, 1, 64'hF3F3_F3F3_F3F3_F3F3);
        step();
        chk("midrst.3beats", {253'd0, burst_read, burst_write, pmem_resp}, 256'd4);
        drive(1, 0, 32'h0040, 1, 64'hF4F4_F4F4_F4F4_F4F4);
        step();
        chk("midrst.done", {253'd0, burst_read, burst_write, pmem_resp}, 256'd1);
        chk("midrst.rdata", pmem_rdata,
            {64'hF4F4_F4F4_F4F4_F4F4, 64'hF3F3_F3F3_F3F3_F3F3,
             64'hF2F2_F2F2_F2F2_F2F2, 64'hF1F1_F1F1_F1F1_F1F1});
        drive(1, 0, 32'h0040, 0, 64'h0);
        step();
        drive(0, 0, 32'h0040, 0, 64'h0);
        step();
        chk("midrst.after", {253'd0, burst_read, burst_write, pmem_resp}, 256'd0);

        // ---------------- spurious burst_resp in IDLE ----------------
        drive(0, 0, 32'h0100, 1, 64'hBAD0_BAD0_BAD0_BAD0);
        step();
        chk("spur.ignored", {253'd0, burst_read, burst_write, pmem_resp}, 256'd0);
        drive(1, 0, 32'h0100, 0, 64'h0);
        step();
        chk("spur.start", {253'd0, burst_read, burst_write, pmem_resp}, 256'd4);
        drive(1, 0, 32'h0100, 1, 64'h5555_5555_5555_5555);
        step();
        drive(1, 0, 32'h0100, 1, 64'h6666_6666_6666_6666);
        step();
        drive(1, 0, 32'h0100, 1, 64'h7777_7777_7777_7777);
        step();
        chk("spur.3beats", {253'd0, burst_read, burst_write, pmem_resp}, 256'd4);
        drive(1, 0, 32'h0100, 1, 64'h8888_8888_8888_8888);
        step();
        chk("spur.done", {253'd0, burst_read, burst_write, pmem_resp}, 256'd1);
        chk("spur.rdata", pmem_rdata,
            {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
             64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
        drive(1, 0, 32'h0100, 0, 64'h0);
        step();
        drive(0, 0, 32'h0100, 0, 64'h0);
        step();
        chk("spur.after", {253'd0, burst_read, burst_write, pmem_resp}, 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
